// File: rtl/moore_pattern_tx_if.sv
// Symbol-stream handshake between a frame requester and moore_pattern_tx.
// The master requests frames; the slave (the transmitter) drives the symbol stream and status.
interface moore_pattern_tx_if #(
   parameter int PAIRS_W = 4
);
   logic               start;
   logic [PAIRS_W-1:0] num_pairs;
   logic               abort;
   logic [1:0]         a;
   logic               busy;
   logic               done;

   modport master (
      output start, num_pairs, abort,
      input  a, busy, done
   );

   modport slave (
      input  start, num_pairs, abort,
      output a, busy, done
   );
endinterface

// File: rtl/moore_pattern_tx.sv
// Framed 2-bit pattern source for the Moore detector: marker 10, then N pairs of 01/00.
// Each symbol is held for HOLD cycles; all outputs are registered from the next state.
//
// state | meaning
// IDLE  | a=00, waiting for start
// MARK  | a=10, frame start marker
// HI    | a=01, first half of a pair
// LO    | a=00, second half of a pair
// DONE  | a=00, one-cycle done pulse
module moore_pattern_tx #(
   parameter int PAIRS_W = 4,
   parameter int HOLD    = 1,
   parameter int HOLD_W  = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   moore_pattern_tx_if.slave    bus
);

   typedef enum logic [2:0] {IDLE, MARK, HI, LO, DONE} state_t;

   state_t              state, state_nxt;
   logic [HOLD_W-1:0]   hold_cnt, hold_cnt_nxt;
   logic [PAIRS_W-1:0]  pair_cnt, pair_cnt_nxt;
   logic [1:0]          a_nxt;
   logic                busy_nxt;
   logic                done_nxt;
   logic                hold_tc;
   logic                in_symbol;

   assign hold_tc   = (hold_cnt == HOLD_W'(HOLD - 1));
   assign in_symbol = (state == MARK) || (state == HI) || (state == LO);

   always_comb begin
      state_nxt    = state;
      pair_cnt_nxt = pair_cnt;
      hold_cnt_nxt = hold_cnt;
      a_nxt        = 2'b00;
      busy_nxt     = 1'b0;
      done_nxt     = 1'b0;

      case (state)
         IDLE: begin
            if (bus.start) begin
               pair_cnt_nxt = bus.num_pairs;
               state_nxt    = MARK;
            end
         end
         MARK: begin
            if (bus.abort)
               state_nxt = IDLE;
            else if (hold_tc)
               state_nxt = (pair_cnt != '0) ? HI : DONE;
         end
         HI: begin
            if (bus.abort)
               state_nxt = IDLE;
            else if (hold_tc)
               state_nxt = LO;
         end
         LO: begin
            if (bus.abort)
               state_nxt = IDLE;
            else if (hold_tc) begin
               // pair_cnt is at least 1 here, so the decrement cannot wrap
               pair_cnt_nxt = pair_cnt - PAIRS_W'(1);
               state_nxt    = (pair_cnt_nxt == '0) ? DONE : HI;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase

      if (state_nxt != state)
         hold_cnt_nxt = '0;
      else if (in_symbol)
         hold_cnt_nxt = hold_cnt + HOLD_W'(1);

      case (state_nxt)
         MARK:    a_nxt = 2'b10;
         HI:      a_nxt = 2'b01;
         default: a_nxt = 2'b00;
      endcase
      busy_nxt = (state_nxt == MARK) || (state_nxt == HI) || (state_nxt == LO);
      done_nxt = (state_nxt == DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         hold_cnt <= '0;
         pair_cnt <= '0;
         bus.a    <= 2'b00;
         bus.busy <= 1'b0;
         bus.done <= 1'b0;
      end else begin
         state    <= state_nxt;
         hold_cnt <= hold_cnt_nxt;
         pair_cnt <= pair_cnt_nxt;
         bus.a    <= a_nxt;
         bus.busy <= busy_nxt;
         bus.done <= done_nxt;
      end
   end

endmodule

// File: tb/tb_moore_pattern_tx.sv
// Directed bench for moore_pattern_tx with HOLD=1 and HOLD=2 instances and a small
// Moore detector on the HOLD=1 stream for loopback comparison.
module tb_moore_pattern_tx;

   logic clk = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   moore_pattern_tx_if #(.PAIRS_W(4)) bus1 ();
   moore_pattern_tx_if #(.PAIRS_W(4)) bus2 ();

   moore_pattern_tx #(.PAIRS_W(4), .HOLD(1), .HOLD_W(4)) dut1 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus1.slave)
   );

   moore_pattern_tx #(.PAIRS_W(4), .HOLD(2), .HOLD_W(4)) dut2 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus2.slave)
   );

   // detector: out=1 the cycle after a 01 symbol is followed by 00
   typedef enum logic [1:0] {D_S0, D_S1, D_S2} det_t;
   det_t det;
   logic det_out;
   assign det_out = (det == D_S2);

   always_ff @(posedge clk) begin
      if (reset)
         det <= D_S0;
      else if (bus1.a == 2'b01)
         det <= D_S1;
      else if ((det == D_S1) && (bus1.a == 2'b00))
         det <= D_S2;
      else
         det <= D_S0;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      bus1.start = 1'b0; bus1.abort = 1'b0;
      bus2.start = 1'b0; bus2.abort = 1'b0;
      step();
      reset = 1'b0;
   endtask

   // start sampled at the next edge (edge 0); returns #1 into cycle 1
   task automatic launch1(input logic [3:0] n);
      @(negedge clk);
      bus1.num_pairs = n;
      bus1.start     = 1'b1;
      step();
      bus1.start     = 1'b0;
      bus1.num_pairs = 4'd3;
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++; if (bus1.a !== 2'b00)  begin n_bad++; $display("FAIL reset_a got %b want 00", bus1.a); end
      n_cmp++; if (bus1.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", bus1.busy); end
      n_cmp++; if (bus1.done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", bus1.done); end
      n_cmp++; if (bus2.a !== 2'b00 || bus2.busy !== 1'b0 || bus2.done !== 1'b0) begin
         n_bad++; $display("FAIL reset_hold2 got a=%b busy=%b done=%b want 00/0/0", bus2.a, bus2.busy, bus2.done);
      end
   endtask

   task automatic test_five_pairs();
      logic [1:0] ea [1:13] = '{2'b10, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00,
                                2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00};
      launch1(4'd5);
      for (int c = 1; c <= 13; c++) begin
         n_cmp++; if (bus1.a !== ea[c]) begin n_bad++; $display("FAIL pairs5_a cyc %0d got %b want %b", c, bus1.a, ea[c]); end
         n_cmp++; if (bus1.busy !== (c <= 11)) begin n_bad++; $display("FAIL pairs5_busy cyc %0d got %b want %b", c, bus1.busy, (c <= 11)); end
         n_cmp++; if (bus1.done !== (c == 12)) begin n_bad++; $display("FAIL pairs5_done cyc %0d got %b want %b", c, bus1.done, (c == 12)); end
         step();
      end
   endtask

   task automatic test_zero_pairs();
      launch1(4'd0);
      n_cmp++; if (bus1.a !== 2'b10 || bus1.busy !== 1'b1) begin n_bad++; $display("FAIL zero_c1 got a=%b busy=%b want 10/1", bus1.a, bus1.busy); end
      step();
      n_cmp++; if (bus1.a !== 2'b00 || bus1.busy !== 1'b0 || bus1.done !== 1'b1) begin
         n_bad++; $display("FAIL zero_c2 got a=%b busy=%b done=%b want 00/0/1", bus1.a, bus1.busy, bus1.done);
      end
      bus1.num_pairs = 4'd2;
      bus1.start = 1'b1;   // sampled in DONE, must be dropped
      step();
      bus1.start = 1'b0;
      n_cmp++; if (bus1.a !== 2'b00 || bus1.busy !== 1'b0 || bus1.done !== 1'b0) begin
         n_bad++; $display("FAIL zero_c3 got a=%b busy=%b done=%b want 00/0/0", bus1.a, bus1.busy, bus1.done);
      end
      step();
      n_cmp++; if (bus1.a !== 2'b00 || bus1.busy !== 1'b0) begin n_bad++; $display("FAIL zero_noqueue got a=%b busy=%b want 00/0", bus1.a, bus1.busy); end
   endtask

   task automatic test_hold2();
      logic [1:0] ea [1:11] = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b00, 2'b00,
                                2'b01, 2'b01, 2'b00, 2'b00, 2'b00};
      @(negedge clk);
      bus2.num_pairs = 4'd2;
      bus2.start = 1'b1;
      step();
      bus2.start = 1'b0;
      bus2.num_pairs = 4'd7;
      for (int c = 1; c <= 11; c++) begin
         n_cmp++; if (bus2.a !== ea[c]) begin n_bad++; $display("FAIL hold2_a cyc %0d got %b want %b", c, bus2.a, ea[c]); end
         n_cmp++; if (bus2.busy !== (c <= 10)) begin n_bad++; $display("FAIL hold2_busy cyc %0d got %b want %b", c, bus2.busy, (c <= 10)); end
         n_cmp++; if (bus2.done !== (c == 11)) begin n_bad++; $display("FAIL hold2_done cyc %0d got %b want %b", c, bus2.done, (c == 11)); end
         step();
      end
   endtask

   task automatic test_back_to_back();
      logic [1:0] ea [1:14] = '{2'b10, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00,
                                2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b10};
      int waited;
      @(negedge clk);
      bus1.num_pairs = 4'd5;
      bus1.start = 1'b1;
      step();
      for (int c = 1; c <= 14; c++) begin
         n_cmp++; if (bus1.a !== ea[c]) begin n_bad++; $display("FAIL b2b_a cyc %0d got %b want %b", c, bus1.a, ea[c]); end
         n_cmp++; if (bus1.busy !== ((c <= 11) || (c == 14))) begin n_bad++; $display("FAIL b2b_busy cyc %0d got %b", c, bus1.busy); end
         n_cmp++; if (bus1.done !== (c == 12)) begin n_bad++; $display("FAIL b2b_done cyc %0d got %b want %b", c, bus1.done, (c == 12)); end
         if (c < 14) step();
      end
      bus1.start = 1'b0;
      waited = 0;
      while (bus1.done !== 1'b1 && waited < 30) begin
         step();
         waited++;
      end
      n_cmp++; if (waited != 11) begin n_bad++; $display("FAIL b2b_second_done got %0d cycles want 11", waited); end
      step();
      n_cmp++; if (bus1.a !== 2'b00 || bus1.busy !== 1'b0 || bus1.done !== 1'b0) begin
         n_bad++; $display("FAIL b2b_idle got a=%b busy=%b done=%b want 00/0/0", bus1.a, bus1.busy, bus1.done);
      end
   endtask

   task automatic test_abort_reset();
      launch1(4'd5);
      step(); step(); step();                 // cycle 4
      n_cmp++; if (bus1.a !== 2'b01) begin n_bad++; $display("FAIL abort_pre got %b want 01", bus1.a); end
      bus1.abort = 1'b1;
      step();                                 // cycle 5
      bus1.abort = 1'b0;
      n_cmp++; if (bus1.a !== 2'b00 || bus1.busy !== 1'b0) begin n_bad++; $display("FAIL abort_c5 got a=%b busy=%b want 00/0", bus1.a, bus1.busy); end
      for (int c = 5; c <= 16; c++) begin
         n_cmp++; if (bus1.done !== 1'b0 || bus1.a !== 2'b00) begin n_bad++; $display("FAIL abort_quiet cyc %0d got a=%b done=%b", c, bus1.a, bus1.done); end
         step();
      end

      // start and abort together in IDLE: start wins
      @(negedge clk);
      bus1.num_pairs = 4'd5;
      bus1.start = 1'b1;
      bus1.abort = 1'b1;
      step();
      bus1.start = 1'b0;
      bus1.abort = 1'b0;
      n_cmp++; if (bus1.a !== 2'b10 || bus1.busy !== 1'b1) begin n_bad++; $display("FAIL start_abort got a=%b busy=%b want 10/1", bus1.a, bus1.busy); end
      for (int c = 2; c <= 6; c++) step();   // cycle 6
      n_cmp++; if (bus1.a !== 2'b01 || bus1.busy !== 1'b1) begin n_bad++; $display("FAIL rst_pre got a=%b busy=%b want 01/1", bus1.a, bus1.busy); end
      reset = 1'b1;
      step();
      reset = 1'b0;
      n_cmp++; if (bus1.a !== 2'b00 || bus1.busy !== 1'b0 || bus1.done !== 1'b0) begin
         n_bad++; $display("FAIL rst_mid got a=%b busy=%b done=%b want 00/0/0", bus1.a, bus1.busy, bus1.done);
      end
      for (int c = 0; c < 10; c++) begin
         step();
         n_cmp++; if (bus1.done !== 1'b0 || bus1.busy !== 1'b0) begin n_bad++; $display("FAIL rst_quiet got busy=%b done=%b want 0/0", bus1.busy, bus1.done); end
      end
   endtask

   task automatic test_loopback();
      logic rec1 [1:14];
      logic rec2 [1:14];
      int ones1;
      int ones2;
      do_reset();
      launch1(4'd5);
      for (int c = 1; c <= 14; c++) begin
         rec1[c] = det_out;
         if (c < 14) step();
      end
      n_cmp++; if (bus1.a !== 2'b00 || bus1.busy !== 1'b0) begin n_bad++; $display("FAIL loop1_idle got a=%b busy=%b want 00/0", bus1.a, bus1.busy); end
      do_reset();
      launch1(4'd5);
      for (int c = 1; c <= 14; c++) begin
         rec2[c] = det_out;
         if (c < 14) step();
      end
      n_cmp++; if (bus1.a !== 2'b00 || bus1.busy !== 1'b0) begin n_bad++; $display("FAIL loop2_idle got a=%b busy=%b want 00/0", bus1.a, bus1.busy); end
      ones1 = 0;
      ones2 = 0;
      for (int c = 1; c <= 14; c++) begin
         if (rec1[c] === 1'b1) ones1++;
         if (rec2[c] === 1'b1) ones2++;
         n_cmp++; if (rec2[c] !== rec1[c]) begin n_bad++; $display("FAIL loop_seq cyc %0d frame2 %b frame1 %b", c, rec2[c], rec1[c]); end
      end
      n_cmp++; if (ones1 != 5) begin n_bad++; $display("FAIL loop_hits1 got %0d want 5", ones1); end
      n_cmp++; if (ones2 != 5) begin n_bad++; $display("FAIL loop_hits2 got %0d want 5", ones2); end
      n_cmp++; if (rec1[4] !== 1'b1 || rec1[12] !== 1'b1 || rec1[3] !== 1'b0) begin
         n_bad++; $display("FAIL loop_pos got c3=%b c4=%b c12=%b want 0/1/1", rec1[3], rec1[4], rec1[12]);
      end
   endtask

   initial begin
      reset = 1'b1;
      bus1.start = 1'b0; bus1.abort = 1'b0; bus1.num_pairs = '0;
      bus2.start = 1'b0; bus2.abort = 1'b0; bus2.num_pairs = '0;
      test_reset();
      test_five_pairs();
      test_zero_pairs();
      test_hold2();
      test_back_to_back();
      test_abort_reset();
      test_loopback();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/moore_pattern_tx.md
Name: moore_pattern_tx

Overview:
Transmitter side of the 2-bit symbol stream consumed by the Moore sequence detector.
- On a start request it emits a framed pattern: start marker 2'b10, then N pairs of 2'b01 / 2'b00, then returns to idle 2'b00.
- Each symbol is held for a programmable number of cycles.
- Its `a` output drives the detector's `a` input directly, as a self-checking stimulus source in loopback benches.

Parameters:
PAIRS_W, 4, width of num_pairs and the internal pair counter
HOLD, 1, clock cycles each symbol is held on a (legal range 1..2**HOLD_W-1)
HOLD_W, 4, width of the internal hold counter

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request to send one frame; sampled only in IDLE
num_pairs  input  PAIRS_W  number of 01/00 pairs to send; latched when start is accepted
abort  input  1  terminate the current frame immediately
a  output  2  symbol stream to the detector
busy  output  1  high while a frame is being emitted
done  output  1  one-cycle pulse after the last symbol of a completed frame

Behaviour:
- Single clock domain (clk). reset is synchronous and active-high.
- All outputs are registered.
- Reset values: a=2'b00, busy=0, done=0, state=IDLE, counters=0.
- Reset has priority over everything else; reset mid-frame returns to IDLE with a=00 on the next cycle and no done pulse.
- States and transitions:
  - IDLE: a=00, busy=0. On start=1, latch num_pairs into pair_cnt, clear hold_cnt, go to MARK.
  - MARK: a=10, busy=1. After HOLD cycles: go to HI if pair_cnt!=0, else go to DONE.
  - HI: a=01, busy=1. After HOLD cycles go to LO.
  - LO: a=00, busy=1. After HOLD cycles, decrement pair_cnt. If the decremented value is 0, go to DONE; else go to HI.
  - DONE: a=00, busy=0, done=1 for exactly one cycle. Go to IDLE unconditionally.
- Latency: start sampled at edge k gives a=10 for cycles k+1..k+HOLD.
- Frame length: 1+2N symbols, i.e. (1+2N)*HOLD cycles with busy=1. done asserts in the cycle immediately after.
- Hold counter: counts 0..HOLD-1 in each symbol state, resets to 0 on every state change. HOLD=1 means one cycle per symbol.
- num_pairs=0: frame is marker only (10, then DONE).
- num_pairs at its maximum value (15 at default width) is sent fully; pair_cnt never wraps.
- start while busy or in DONE is ignored and not queued.
- num_pairs changes after acceptance have no effect on the current frame.
- abort=1 in MARK/HI/LO: next cycle state=IDLE, a=00, busy=0, done stays 0.
- abort in IDLE or DONE has no effect. If start and abort are both high in IDLE, start is accepted and the abort is ignored.

Test Plan:
1. HOLD=1, reset 1 cycle, num_pairs=5, start pulse sampled at edge 0 -> a = 10,01,00,01,00,01,00,01,00,01,00 on cycles 1..11; busy=1 on cycles 1..11; done=1 only on cycle 12; a=00, busy=0 from cycle 12.
2. HOLD=1, num_pairs=0, start -> a=10 on cycle 1 only; done=1 on cycle 2; back in IDLE on cycle 3.
3. HOLD=2, num_pairs=2, start -> a = 10,10,01,01,00,00,01,01,00,00 on cycles 1..10; done on cycle 11.
4. HOLD=1, num_pairs=5, start held high continuously -> frame identical to scenario 1; a new frame's 10 appears on cycle 14 (start accepted in IDLE at cycle 13), with no extra or overlapping frame.
5. HOLD=1, num_pairs=5, abort pulse at cycle 4 (a=01) -> cycle 5: a=00, busy=0; done never asserts. Reset pulse at cycle 6 of a fresh frame -> a=00, busy=0 next cycle; no done.
6. Loopback: a drives the moore detector instance, running the scenario 1 frame twice with a reset between -> detector out sequence identical for both frames; transmitter returns to a=00, busy=0 after each.
